serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 16 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM state, glyph constants and default width for serial_adder
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } adder_state_t;

    // Active-low abcdefg segment patterns
    localparam logic [6:0] GLYPH_S = 7'b0100100;
    localparam logic [6:0] GLYPH_C = 7'b0110001;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder step
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder with sum/carry display; SERIAL_ADDER_ACCUM_EN adds ACC feedback
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_ACCUM_EN
    input  logic             ACC,
`endif
    input  logic             FLIP,
    output logic [WIDTH-1:0] LED,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [6:0]       SLED
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    adder_state_t state_q, state_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] sum_q, cvec_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             cout_q;
    logic             step_s, step_c;
    logic [WIDTH-1:0] first_op;

`ifdef SERIAL_ADDER_ACCUM_EN
    assign first_op = ACC ? sum_q : A;
`else
    assign first_op = A;
`endif

    full_adder_cell u_cell (
        .a    (op_a[idx]),
        .b    (op_b[idx]),
        .cin  (carry),
        .s    (step_s),
        .cout (step_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = RUN;
            RUN:     if (idx == LAST_IDX) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            cvec_q <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        op_a   <= first_op;
                        op_b   <= B;
                        sum_q  <= '0;
                        cvec_q <= '0;
                        idx    <= '0;
                        carry  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[idx]  <= step_s;
                    cvec_q[idx] <= step_c;
                    carry       <= step_c;
                    idx         <= idx + 1'b1;
                end
                FIN:     cout_q <= carry;
                default: ;
            endcase
        end
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign LED  = FLIP ? cvec_q : sum_q;
    assign SLED = FLIP ? GLYPH_C : GLYPH_S;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST, START, FLIP, ACC;
    logic [W-1:0] A, B, LED, SUM;
    logic         COUT, BUSY, DONE;
    logic [6:0]   SLED;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADDER_ACCUM_EN
        .ACC   (ACC),
`endif
        .FLIP  (FLIP),
        .LED   (LED),
        .SUM   (SUM),
        .COUT  (COUT),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SLED  (SLED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts cycles from the START cycle (cycle 0) to the DONE cycle.
    task automatic wait_done(input bit scramble, output int n);
        n = 1;
        while (!DONE && n < 40) begin
            tick();
            n++;
            if (scramble) begin
                A = W'($urandom);
                B = W'($urandom);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acc, input bit scramble,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic [W-1:0] exp_cvec);
        int n;
        A = a; B = b; ACC = acc; START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(scramble, n);
        check({tag, "_latency"}, n, W + 1);
        tick();
        check({tag, "_busy_idle"}, BUSY, 0);
        check({tag, "_sum"}, SUM, exp_sum);
        check({tag, "_cout"}, COUT, exp_cout);
        FLIP = 1'b0; #1;
        check({tag, "_led_sum"}, LED, exp_sum);
        check({tag, "_sled_s"}, SLED, 7'b0100100);
        FLIP = 1'b1; #1;
        check({tag, "_led_cvec"}, LED, exp_cvec);
        check({tag, "_sled_c"}, SLED, 7'b0110001);
        FLIP = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        RST = 1'b1; START = 1'b0; FLIP = 1'b0; ACC = 1'b0; A = '0; B = '0;
        tick(); tick();
        check("rst_sum", SUM, 0);
        check("rst_cout", COUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        RST = 1'b0;
        tick();

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 8'h0F);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF);
        run_op("scramble",  8'h3C, 8'h0A, 1'b0, 1'b1, 8'h46, 1'b0, 8'h38);

        // START held high: back-to-back operations, never accepted in the DONE cycle
        A = 8'h03; B = 8'h04; START = 1'b1;
        tick();
        wait_done(1'b0, n);
        check("held_first_latency", n, W + 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("held_idle_busy", BUSY, 0);
            check("held_idle_done", DONE, 0);
            tick();
            check("held_run_busy", BUSY, 1);
            n = 2;
            while (!DONE && n < 40) begin
                tick();
                n++;
            end
            check("held_period", n, W + 2);
            check("held_sum", SUM, 8'h07);
        end
        START = 1'b0;
        tick();

        // Reset in the 4th RUN cycle aborts with no DONE
        A = 8'hAA; B = 8'h55; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        check("abort_busy_before", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_sum", SUM, 0);
        check("abort_cout", COUT, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_led", LED, 0);
        FLIP = 1'b1; #1;
        check("abort_cvec", LED, 0);
        FLIP = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (DONE || BUSY) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);

`ifdef SERIAL_ADDER_ACCUM_EN
        run_op("acc0", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 8'h07);
        run_op("acc1", 8'hF0, 8'h04, 1'b1, 1'b0, 8'h0C, 1'b0, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
